// File: rtl/mic_level_monitor_pkg.sv
// Shared types and the offset-removing rectifier for the mic level monitor.
// Pure combinational helpers; no latency; no backpressure.
package mic_level_monitor_pkg;

    typedef enum logic [1:0] {
        MODE_LATEST = 2'd0,
        MODE_PEAK   = 2'd1,
        MODE_MEAN   = 2'd2,
        MODE_RSVD   = 2'd3
    } disp_mode_t;

    localparam int MAX_CH = 8;
    localparam int MAX_W  = 32;

    // Callers sign-extend their DATA_W operands to MAX_W and keep the low DATA_W+1 bits.
    function automatic logic [MAX_W:0] rectify(input logic signed [MAX_W-1:0] smp,
                                               input logic signed [MAX_W-1:0] off);
        logic signed [MAX_W:0] d;
        d = {smp[MAX_W-1], smp} - {off[MAX_W-1], off};
        return d[MAX_W] ? -d : d;
    endfunction

endpackage

// File: rtl/mic_level_monitor_chan_stats.sv
// Per-channel rectify and LATEST/PEAK/MEAN window statistics with next-state forwarding.
// result/seen_any are combinational from registered state plus the current strobe; no backpressure.
module mic_chan_stats
    import mic_level_monitor_pkg::*;
#(
    parameter int DATA_W   = 18,
    parameter int OUT_W    = 32,
    parameter int AVG_LOG2 = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] calib,
    input  logic              sample_rdy,
    input  logic              tick,
    input  logic [1:0]        mode_q,
    output logic [OUT_W-1:0]  result,
    output logic              seen_any
);

    localparam int R_W = DATA_W + 1;
    localparam int S_W = R_W + AVG_LOG2;
    localparam int N_W = AVG_LOG2 + 1;
    localparam logic [N_W-1:0] N_FULL = N_W'(2 ** AVG_LOG2);

    logic [R_W-1:0] r;
    logic [R_W-1:0] last_q, last_nx;
    logic [R_W-1:0] peak_q, peak_nx;
    logic [S_W-1:0] sum_q, sum_nx;
    logic [N_W-1:0] n_q, n_nx;
    logic           seen_q, seen_nx;

    assign r = R_W'(rectify(MAX_W'($signed(sample)), MAX_W'($signed(calib))));

    always_comb begin
        last_nx = last_q;
        peak_nx = peak_q;
        sum_nx  = sum_q;
        n_nx    = n_q;
        seen_nx = seen_q | sample_rdy;
        if (sample_rdy) begin
            last_nx = r;
            if (r > peak_q) peak_nx = r;
            if (n_q < N_FULL) begin
                sum_nx = sum_q + S_W'(r);
                n_nx   = n_q + N_W'(1);
            end
        end
    end

    // The published value sees the strobe that lands on the tick cycle.
    always_comb begin
        case (disp_mode_t'(mode_q))
            MODE_PEAK: result = OUT_W'(peak_nx);
            MODE_MEAN: result = OUT_W'(sum_nx >> AVG_LOG2);
            default:   result = OUT_W'(last_nx);
        endcase
    end

    assign seen_any = seen_nx;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= '0;
            peak_q <= '0;
            sum_q  <= '0;
            n_q    <= '0;
            seen_q <= 1'b0;
        end else if (tick) begin
            last_q <= last_nx;
            peak_q <= '0;
            sum_q  <= '0;
            n_q    <= '0;
            seen_q <= 1'b0;
        end else begin
            last_q <= last_nx;
            peak_q <= peak_nx;
            sum_q  <= sum_nx;
            n_q    <= n_nx;
            seen_q <= seen_nx;
        end
    end

endmodule

// File: rtl/mic_level_monitor.sv
// Multi-channel mic level monitor publishing one LATEST/PEAK/MEAN value per channel per window.
// Publish visible one cycle after the tick cycle, disp_sel one cycle later; no backpressure.
module mic_level_monitor
    import mic_level_monitor_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int DATA_W         = 18,
    parameter int OUT_W          = 32,
    parameter int REFRESH_CYCLES = 10_000_000,
    parameter int AVG_LOG2       = 4,
    localparam int SEL_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_CH*DATA_W-1:0] data,
    input  logic [N_CH-1:0]        data_rdy,
    input  logic [N_CH*DATA_W-1:0] calib,
    input  logic [1:0]             mode,
    input  logic [SEL_W-1:0]       sel,
    output logic [N_CH*OUT_W-1:0]  disp_val,
    output logic [OUT_W-1:0]       disp_sel,
    output logic                   disp_valid,
    output logic [N_CH-1:0]        stale
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [1:0]       mode_q;
    logic [OUT_W-1:0] res   [N_CH];
    logic [OUT_W-1:0] val_q [N_CH];
    logic [N_CH-1:0]  seen;
    logic [OUT_W-1:0] sel_val;

    assign tick = (cnt == CNT_LAST);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mic_chan_stats #(
            .DATA_W   (DATA_W),
            .OUT_W    (OUT_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_stats (
            .clock      (clock),
            .reset      (reset),
            .sample     (data[g*DATA_W +: DATA_W]),
            .calib      (calib[g*DATA_W +: DATA_W]),
            .sample_rdy (data_rdy[g]),
            .tick       (tick),
            .mode_q     (mode_q),
            .result     (res[g]),
            .seen_any   (seen[g])
        );
        assign disp_val[g*OUT_W +: OUT_W] = val_q[g];
    end

    // Out-of-range sel matches no channel and reads as zero.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (SEL_W'(k) == sel) sel_val = val_q[k];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            mode_q     <= MODE_LATEST;
            disp_valid <= 1'b0;
            disp_sel   <= '0;
            stale      <= '0;
            for (int k = 0; k < N_CH; k++) val_q[k] <= '0;
        end else begin
            cnt        <= tick ? '0 : cnt + CNT_W'(1);
            disp_valid <= tick;
            disp_sel   <= sel_val;
            if (tick) begin
                mode_q <= mode;
                for (int k = 0; k < N_CH; k++) begin
                    if (seen[k]) val_q[k] <= res[k];
                    stale[k] <= ~seen[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_mic_level_monitor.sv
// Scoreboard bench for mic_level_monitor: windows of directed samples, expected publishes queued.
// Monitor pops on each disp_valid and also checks publish period and the registered disp_sel.
module tb_mic_level_monitor;

    localparam int N_CH = 2;
    localparam int DATA_W = 18;
    localparam int OUT_W = 32;
    localparam int RC = 8;
    localparam int AL = 2;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [N_CH*DATA_W-1:0] data;
    logic [N_CH-1:0]        data_rdy;
    logic [N_CH*DATA_W-1:0] calib;
    logic [1:0]             mode;
    logic                   sel;
    logic [N_CH*OUT_W-1:0]  disp_val;
    logic [OUT_W-1:0]       disp_sel;
    logic                   disp_valid;
    logic [N_CH-1:0]        stale;

    mic_level_monitor #(
        .N_CH(N_CH), .DATA_W(DATA_W), .OUT_W(OUT_W), .REFRESH_CYCLES(RC), .AVG_LOG2(AL)
    ) dut (
        .clock(clock), .reset(reset), .data(data), .data_rdy(data_rdy), .calib(calib),
        .mode(mode), .sel(sel), .disp_val(disp_val), .disp_sel(disp_sel),
        .disp_valid(disp_valid), .stale(stale)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] v0;
        logic [31:0] v1;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   since = 0;
    int   n_pub = 0;
    bit   sel_pend = 1'b0;
    logic [31:0] sel_exp;

    bit          v_a [2][8];
    logic [17:0] d_a [2][8];
    logic [1:0]  m_a [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic clr_win();
        for (int ch = 0; ch < 2; ch++)
            for (int c = 0; c < 8; c++) begin
                v_a[ch][c] = 1'b0;
                d_a[ch][c] = '0;
            end
        for (int c = 0; c < 7; c++) m_a[c] = m_a[7];
    endtask

    task automatic put(input int ch, input int c, input int val);
        v_a[ch][c] = 1'b1;
        d_a[ch][c] = 18'(val);
    endtask

    task automatic set_mode(input int from, input logic [1:0] m);
        for (int c = from; c < 8; c++) m_a[c] = m;
    endtask

    task automatic run_cycles(input int first, input int last);
        for (int c = first; c <= last; c++) begin
            data_rdy = {v_a[1][c], v_a[0][c]};
            data     = {d_a[1][c], d_a[0][c]};
            mode     = m_a[c];
            @(posedge clock);
            #1;
        end
        data_rdy = '0;
    endtask

    task automatic win(input int v0, input int v1, input logic [1:0] st);
        exp_t x;
        x.v0 = 32'(v0);
        x.v1 = 32'(v1);
        x.st = st;
        exp_q.push_back(x);
        run_cycles(0, 7);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_disp_val"}, 64'(disp_val), 64'd0);
        chk({tag, "_disp_sel"}, 64'(disp_sel), 64'd0);
        chk({tag, "_disp_valid"}, 64'(disp_valid), 64'd0);
        chk({tag, "_stale"}, 64'(stale), 64'd0);
    endtask

    always @(negedge clock) begin
        if (sel_pend) begin
            chk("disp_sel", 64'(disp_sel), 64'(sel_exp));
            sel_pend = 1'b0;
        end
        if (reset) begin
            since = 0;
        end else if (disp_valid) begin
            chk("pulse_period", 64'(since), 64'(RC));
            since = 1;
            n_pub++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_publish: got publish %0d, required none", n_pub);
            end else begin
                e = exp_q.pop_front();
                chk("disp_val0", 64'(disp_val[31:0]), 64'(e.v0));
                chk("disp_val1", 64'(disp_val[63:32]), 64'(e.v1));
                chk("stale", 64'(stale), 64'(e.st));
                sel_exp = sel ? e.v1 : e.v0;
                sel_pend = 1'b1;
            end
        end else begin
            since++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        data = '0;
        data_rdy = '0;
        calib = '0;
        mode = 2'd0;
        sel = 1'b0;
        for (int c = 0; c < 8; c++) m_a[c] = 2'd0;
        repeat (3) @(posedge clock);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // LATEST; switch to PEAK late so it governs the next window only
        clr_win(); put(0, 1, -5); put(0, 3, 7); put(0, 5, -9); set_mode(6, 1);
        win(9, 0, 2'b10);
        // PEAK with ch1 offset 100
        calib[35:18] = 18'd100;
        clr_win(); put(1, 0, 90); put(1, 2, 130); put(1, 4, 101);
        win(9, 30, 2'b01);
        // PEAK still; mid-window request for MEAN must not leak in
        clr_win(); put(0, 1, 3); put(0, 5, -1); set_mode(3, 2);
        win(3, 30, 2'b10);
        // MEAN: fifth sample ignored
        clr_win(); put(0, 0, 4); put(0, 1, 8); put(0, 2, 12); put(0, 3, 16); put(0, 4, 1000);
        win(10, 30, 2'b10);
        // MEAN short window: single 8 -> 2; ch1 at its offset -> 0
        clr_win(); put(0, 2, 8); put(1, 3, 100); set_mode(5, 1);
        win(2, 0, 2'b00);
        // PEAK with a sample on the tick cycle
        clr_win(); put(0, 1, 20); put(0, 7, 50);
        win(50, 0, 2'b10);
        // peak restarts from 0
        clr_win(); put(0, 2, 5); set_mode(6, 0);
        win(5, 0, 2'b10);
        // LATEST, switched to PEAK mid-window
        clr_win(); put(0, 1, 30); put(0, 3, 7); set_mode(4, 1);
        win(7, 0, 2'b10);
        clr_win(); put(0, 1, 30); put(0, 3, 7); set_mode(6, 3);
        win(30, 0, 2'b10);
        // reserved mode behaves as LATEST
        clr_win(); put(0, 1, 30); put(0, 3, 7); set_mode(4, 0);
        win(7, 0, 2'b10);

        // reset on cycle 5 of a window discards it
        clr_win(); put(0, 1, 99);
        run_cycles(0, 4);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk_zero("midreset");
        sel = 1'b1;
        calib = {18'd131071, 18'd0};
        reset = 1'b0;
        clr_win(); put(1, 2, -131072);
        win(0, 262143, 2'b01);

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("publish_count", 64'(n_pub), 64'd11);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
